// File: rtl/gpio_pkg.sv
// Shared definitions for the Wishbone GPIO controller: register addresses,
// bus widths, bus FSM states and the byte-lane mask helper.
package gpio_pkg;

    localparam int GPIO_ADR_W = 4;
    localparam int GPIO_DW    = 32;

    localparam logic [GPIO_ADR_W-1:0] GPIO_OUT_ADR    = 4'h0;
    localparam logic [GPIO_ADR_W-1:0] GPIO_DIR_ADR    = 4'h1;
    localparam logic [GPIO_ADR_W-1:0] GPIO_IN_ADR     = 4'h2;
    localparam logic [GPIO_ADR_W-1:0] GPIO_IRQ_EN_ADR = 4'h3;
    localparam logic [GPIO_ADR_W-1:0] GPIO_RISE_ADR   = 4'h4;
    localparam logic [GPIO_ADR_W-1:0] GPIO_FALL_ADR   = 4'h5;
    localparam logic [GPIO_ADR_W-1:0] GPIO_STATUS_ADR = 4'h6;

    typedef enum logic {
        BUS_IDLE,
        BUS_RESP
    } busState_e;

    // Expands the per-byte select into a per-bit write mask.
    function automatic logic [GPIO_DW-1:0] byteMask(input logic [GPIO_DW/8-1:0] sel);
        logic [GPIO_DW-1:0] mask;
        for (int b = 0; b < GPIO_DW/8; b++) begin
            mask[b*8 +: 8] = {8{sel[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Pad input synchroniser with a one-cycle history register, producing
// per-pin rising/falling edge pulses from the last synchroniser stage.
module gpio_sync_edge #(
    parameter int W           = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] async_i,
    output logic [W-1:0] sync_o,
    output logic [W-1:0] rise_o,
    output logic [W-1:0] fall_o
);

    logic [SYNC_STAGES-1:0][W-1:0] stage_q;
    logic [W-1:0]                  prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_q <= '0;
            prev_q  <= '0;
        end else begin
            stage_q <= {stage_q[SYNC_STAGES-2:0], async_i};
            prev_q  <= stage_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = stage_q[SYNC_STAGES-1];
    assign rise_o = stage_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o = ~stage_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/wb_gpio_ctrl.sv
// Wishbone-slave GPIO controller: register file, single-cycle-response bus
// FSM and edge-triggered interrupt status with write-1-to-clear.
module wb_gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int GPIO_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [GPIO_ADR_W-1:0] wb_adr_i,
    input  logic [GPIO_DW/8-1:0]  wb_sel_i,
    input  logic [GPIO_DW-1:0]    wb_dat_i,
    output logic [GPIO_DW-1:0]    wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    input  logic [GPIO_W-1:0]     gpio_i,
    output logic [GPIO_W-1:0]     gpio_o,
    output logic [GPIO_W-1:0]     gpio_oe_o,
    output logic                  irq_o
);

    busState_e state_q, state_d;
    logic ack_q, ack_d;
    logic err_q, err_d;
    logic irq_q, irq_d;
    logic [GPIO_DW-1:0] dat_q, dat_d;

    logic [GPIO_W-1:0] out_q, out_d;
    logic [GPIO_W-1:0] dir_q, dir_d;
    logic [GPIO_W-1:0] irqEn_q, irqEn_d;
    logic [GPIO_W-1:0] riseSel_q, riseSel_d;
    logic [GPIO_W-1:0] fallSel_q, fallSel_d;
    logic [GPIO_W-1:0] status_q, status_d;

    logic [GPIO_W-1:0]  pinSync, pinRise, pinFall;
    logic [GPIO_W-1:0]  setBits, clrBits;
    logic [GPIO_W-1:0]  wrMask, wrData;
    logic [GPIO_DW-1:0] laneMask;
    logic [GPIO_DW-1:0] rdData;
    logic               adrMapped;

    gpio_sync_edge #(
        .W           (GPIO_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .async_i (gpio_i),
        .sync_o  (pinSync),
        .rise_o  (pinRise),
        .fall_o  (pinFall)
    );

    assign setBits   = irqEn_q & ((riseSel_q & pinRise) | (fallSel_q & pinFall));
    assign laneMask  = byteMask(wb_sel_i);
    assign wrMask    = laneMask[GPIO_W-1:0];
    assign wrData    = wb_dat_i[GPIO_W-1:0];
    assign adrMapped = (wb_adr_i <= GPIO_STATUS_ADR);

    // Pins above GPIO_W read back as zero because only the low slice is filled.
    always_comb begin
        rdData = '0;
        case (wb_adr_i)
            GPIO_OUT_ADR:    rdData[GPIO_W-1:0] = out_q;
            GPIO_DIR_ADR:    rdData[GPIO_W-1:0] = dir_q;
            GPIO_IN_ADR:     rdData[GPIO_W-1:0] = pinSync;
            GPIO_IRQ_EN_ADR: rdData[GPIO_W-1:0] = irqEn_q;
            GPIO_RISE_ADR:   rdData[GPIO_W-1:0] = riseSel_q;
            GPIO_FALL_ADR:   rdData[GPIO_W-1:0] = fallSel_q;
            GPIO_STATUS_ADR: rdData[GPIO_W-1:0] = status_q;
            default:         rdData = '0;
        endcase
    end

    // A request is only accepted from IDLE, which forces a gap after every response.
    always_comb begin
        state_d   = state_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        dat_d     = '0;
        out_d     = out_q;
        dir_d     = dir_q;
        irqEn_d   = irqEn_q;
        riseSel_d = riseSel_q;
        fallSel_d = fallSel_q;
        clrBits   = '0;

        unique case (state_q)
            BUS_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    state_d = BUS_RESP;
                    if (adrMapped) begin
                        ack_d = 1'b1;
                        if (wb_we_i) begin
                            case (wb_adr_i)
                                GPIO_OUT_ADR:    out_d     = (out_q & ~wrMask) | (wrData & wrMask);
                                GPIO_DIR_ADR:    dir_d     = (dir_q & ~wrMask) | (wrData & wrMask);
                                GPIO_IRQ_EN_ADR: irqEn_d   = (irqEn_q & ~wrMask) | (wrData & wrMask);
                                GPIO_RISE_ADR:   riseSel_d = (riseSel_q & ~wrMask) | (wrData & wrMask);
                                GPIO_FALL_ADR:   fallSel_d = (fallSel_q & ~wrMask) | (wrData & wrMask);
                                GPIO_STATUS_ADR: clrBits   = wrData & wrMask;
                                default:         clrBits   = '0;
                            endcase
                        end else begin
                            dat_d = rdData;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            BUS_RESP: state_d = BUS_IDLE;
            default:  state_d = BUS_IDLE;
        endcase

        status_d = (status_q & ~clrBits) | setBits;
        irq_d    = |status_q;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= BUS_IDLE;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            dat_q     <= '0;
            irq_q     <= 1'b0;
            out_q     <= '0;
            dir_q     <= '0;
            irqEn_q   <= '0;
            riseSel_q <= '0;
            fallSel_q <= '0;
            status_q  <= '0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            dat_q     <= dat_d;
            irq_q     <= irq_d;
            out_q     <= out_d;
            dir_q     <= dir_d;
            irqEn_q   <= irqEn_d;
            riseSel_q <= riseSel_d;
            fallSel_q <= fallSel_d;
            status_q  <= status_d;
        end
    end

    assign wb_ack_o  = ack_q;
    assign wb_err_o  = err_q;
    assign wb_dat_o  = dat_q;
    assign gpio_o    = out_q;
    assign gpio_oe_o = dir_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_wb_gpio_ctrl.sv
// Directed self-checking bench for wb_gpio_ctrl: bus access, lane masking,
// edge interrupts with W1C status, and asynchronous reset mid-transfer.
module tb_wb_gpio_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  adr;
    logic [3:0]  sel;
    logic [31:0] datIn;
    logic [31:0] datOut;
    logic        ack, err;
    logic [31:0] gpioIn;
    logic [31:0] gpioOut, gpioOe;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [31:0] rdat;
    logic        rack, rerr;

    wb_gpio_ctrl #(
        .GPIO_W      (32),
        .SYNC_STAGES (2)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wb_cyc_i  (cyc),
        .wb_stb_i  (stb),
        .wb_we_i   (we),
        .wb_adr_i  (adr),
        .wb_sel_i  (sel),
        .wb_dat_i  (datIn),
        .wb_dat_o  (datOut),
        .wb_ack_o  (ack),
        .wb_err_o  (err),
        .gpio_i    (gpioIn),
        .gpio_o    (gpioOut),
        .gpio_oe_o (gpioOe),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Starts on the next falling edge, returns on the falling edge after the response edge.
    task automatic applyStimulus(input logic wr, input logic [3:0] a, input logic [3:0] s,
                                 input logic [31:0] d, output logic [31:0] rd,
                                 output logic rAck, output logic rErr);
        @(negedge clk);
        cyc   = 1'b1;
        stb   = 1'b1;
        we    = wr;
        adr   = a;
        sel   = s;
        datIn = d;
        @(posedge clk);
        @(negedge clk);
        rd    = datOut;
        rAck  = ack;
        rErr  = err;
        cyc   = 1'b0;
        stb   = 1'b0;
        we    = 1'b0;
    endtask

    task automatic wbWrite(input string tag, input logic [3:0] a, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] rd;
        logic        rAck, rErr;
        applyStimulus(1'b1, a, s, d, rd, rAck, rErr);
        checkOutput({tag, "_ack"}, {31'b0, rAck}, 32'h1);
    endtask

    task automatic wbRead(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        logic        rAck, rErr;
        applyStimulus(1'b0, a, 4'h0, 32'h0, rd, rAck, rErr);
        checkOutput({tag, "_ack"}, {31'b0, rAck}, 32'h1);
        checkOutput({tag, "_dat"}, rd, exp);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst    = 1'b1;
        cyc    = 1'b0;
        stb    = 1'b0;
        we     = 1'b0;
        adr    = 4'h0;
        sel    = 4'h0;
        datIn  = 32'h0;
        gpioIn = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        checkOutput("rst_gpio_o", gpioOut, 32'h0);
        checkOutput("rst_gpio_oe", gpioOe, 32'h0);
        checkOutput("rst_irq", {31'b0, irq}, 32'h0);
        checkOutput("rst_ack", {31'b0, ack}, 32'h0);
        checkOutput("rst_err", {31'b0, err}, 32'h0);
        checkOutput("rst_dat", datOut, 32'h0);

        for (int a = 0; a < 7; a++) begin
            wbRead($sformatf("rst_reg%0d", a), 4'(a), 32'h0);
        end

        applyStimulus(1'b0, 4'h9, 4'h0, 32'h0, rdat, rack, rerr);
        checkOutput("unmapped_err", {31'b0, rerr}, 32'h1);
        checkOutput("unmapped_ack", {31'b0, rack}, 32'h0);
        checkOutput("unmapped_dat", rdat, 32'h0);

        wbWrite("dir_wr", 4'h1, 4'b0011, 32'hFFFF_FFFF);
        checkOutput("dir_pins", gpioOe, 32'h0000_FFFF);
        wbWrite("out_wr", 4'h0, 4'b1111, 32'hA5A5_A5A5);
        checkOutput("out_pins", gpioOut, 32'hA5A5_A5A5);
        wbRead("dir_rd", 4'h1, 32'h0000_FFFF);
        wbRead("out_rd", 4'h0, 32'hA5A5_A5A5);
        wbWrite("in_wr", 4'h2, 4'b1111, 32'hFFFF_FFFF);
        wbRead("in_rd", 4'h2, 32'h0);

        wbWrite("en3_wr", 4'h3, 4'b0001, 32'h0000_0008);
        wbWrite("rise3_wr", 4'h4, 4'b0001, 32'h0000_0008);
        gpioIn[3] = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rise3_irq_early", {31'b0, irq}, 32'h0);
        @(negedge clk);
        checkOutput("rise3_irq", {31'b0, irq}, 32'h1);
        wbRead("rise3_in", 4'h2, 32'h0000_0008);
        wbRead("rise3_status", 4'h6, 32'h0000_0008);

        wbWrite("w1c_nolane", 4'h6, 4'b0000, 32'h0000_0008);
        wbRead("w1c_nolane_status", 4'h6, 32'h0000_0008);
        wbWrite("w1c_lane0", 4'h6, 4'b0001, 32'h0000_0008);
        checkOutput("w1c_irq_hold", {31'b0, irq}, 32'h1);
        @(negedge clk);
        checkOutput("w1c_irq_drop", {31'b0, irq}, 32'h0);

        gpioIn[3] = 1'b0;
        repeat (5) @(negedge clk);
        wbRead("fall3_status", 4'h6, 32'h0);
        checkOutput("fall3_irq", {31'b0, irq}, 32'h0);

        wbWrite("en_any_wr", 4'h3, 4'b0001, 32'h0000_0009);
        wbWrite("rise_any_wr", 4'h4, 4'b0001, 32'h0000_0009);
        wbWrite("fall_any_wr", 4'h5, 4'b0001, 32'h0000_0001);
        gpioIn[0] = 1'b1;
        repeat (2) @(negedge clk);
        wbWrite("any_clr", 4'h6, 4'b0001, 32'h0000_0001);
        gpioIn[0] = 1'b0;
        @(negedge clk);
        checkOutput("any_cleared_irq", {31'b0, irq}, 32'h0);
        repeat (4) @(negedge clk);
        checkOutput("any_fall_irq", {31'b0, irq}, 32'h1);
        wbRead("any_fall_status", 4'h6, 32'h0000_0001);

        wbWrite("pre_race_clr", 4'h6, 4'b0001, 32'h0000_0001);
        wbRead("pre_race_status", 4'h6, 32'h0);
        gpioIn[0] = 1'b1;
        @(negedge clk);
        wbWrite("race_clr", 4'h6, 4'b0001, 32'h0000_0001);
        wbRead("race_status", 4'h6, 32'h0000_0001);

        @(negedge clk);
        cyc   = 1'b1;
        stb   = 1'b1;
        we    = 1'b1;
        adr   = 4'h0;
        sel   = 4'b1111;
        datIn = 32'hFFFF_FFFF;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_gpio_o", gpioOut, 32'h0);
        checkOutput("rst_mid_ack", {31'b0, ack}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_mid_ack_edge", {31'b0, ack}, 32'h0);
        checkOutput("rst_mid_gpio_o_edge", gpioOut, 32'h0);
        checkOutput("rst_mid_gpio_oe", gpioOe, 32'h0);
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        rst = 1'b0;
        wbWrite("post_rst_wr", 4'h0, 4'b1111, 32'h1234_5678);
        checkOutput("post_rst_pins", gpioOut, 32'h1234_5678);
        wbRead("post_rst_rd", 4'h0, 32'h1234_5678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
